// File: rtl/led_mux_pkg.sv
// Shared types and constants for the multiplexed LED digit driver.
// Segment lines are active-low, so the all-ones pattern is a dark digit.
package led_mux_pkg;

  localparam int unsigned SEG_BITS = 8;

  typedef logic [SEG_BITS-1:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam logic [3:0] BRIGHT_OFF  = 4'd0;
  localparam logic [3:0] BRIGHT_FULL = 4'd15;

endpackage

// File: rtl/led_slot_cnt.sv
// Slot prescaler: modulo-DIV counter. o_wrap is high during the final cycle of
// a slot, so the state update on that edge starts the next slot.
module led_slot_cnt #(
  parameter int unsigned DIV = 50000,
  parameter int unsigned CW  = $clog2(DIV)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    o_wrap = (cnt_q == CW'(DIV - 1));
    cnt_d  = o_wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/led_n_mux.sv
// Time-multiplexed driver for N_DIGITS LED digits with PWM brightness.
// Define LEDMUX_BLANK_EN to add a dark period of BLANK cycles at every slot start.
module led_n_mux
  import led_mux_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SEG_W    = 8,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned BLANK    = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [N_DIGITS-1:0][SEG_W-1:0]       i_in_n,
  input  logic [N_DIGITS-1:0]                  i_dig_en,
  input  logic [3:0]                           i_bright,
  output logic [N_DIGITS-1:0]                  o_ldsel,
  output logic [SEG_W-1:0]                     o_sseg_n,
  output logic [$clog2(N_DIGITS)-1:0]          o_digit_idx,
  output logic                                 o_scan_tick
);

  localparam int unsigned IW   = $clog2(N_DIGITS);
  localparam int unsigned CW   = $clog2(DIV);
  localparam int unsigned REPS = (SEG_W + SEG_BITS - 1) / SEG_BITS;
  localparam logic [REPS*SEG_BITS-1:0] OFF_WIDE = {REPS{SEG_BLANK}};
  localparam logic [SEG_W-1:0] SEG_OFF = OFF_WIDE[SEG_W-1:0];

  logic [CW-1:0]       cnt;
  logic                wrap;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          pwm_q, pwm_d;
  logic                started_q, started_d;
  logic [N_DIGITS-1:0] ldsel_q, ldsel_d;
  logic [SEG_W-1:0]    sseg_q, sseg_d;
  logic [IW-1:0]       digit_idx_q;
  logic                tick_q, tick_d;
  logic                bright_ok;
  logic                blank_act;
  logic                lit;

  led_slot_cnt #(
    .DIV (DIV),
    .CW  (CW)
  ) u_slot_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_cnt   (cnt),
    .o_wrap  (wrap)
  );

`ifdef LEDMUX_BLANK_EN
  assign blank_act = (32'(cnt) < 32'(BLANK));
`else
  // BLANK has no effect in this build.
  logic [31:0] unused_blank;
  assign unused_blank = 32'(BLANK);
  assign blank_act    = 1'b0;
`endif

  // Full brightness must bypass the compare: pwm never gets below 15 at pwm == 15.
  always_comb begin
    bright_ok = (i_bright != BRIGHT_OFF) &&
                ((pwm_q < i_bright) || (i_bright == BRIGHT_FULL));
    lit       = i_dig_en[idx_q] && bright_ok && !blank_act;
  end

  always_comb begin
    idx_d     = idx_q;
    started_d = started_q;
    if (wrap) begin
      idx_d     = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      started_d = 1'b1;
    end
    pwm_d   = pwm_q + 4'd1;
    ldsel_d = lit ? (N_DIGITS'(1) << idx_q) : '0;
    sseg_d  = lit ? i_in_n[idx_q] : SEG_OFF;
    // The very first slot after reset is not announced.
    tick_d  = started_q && (cnt == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idx_q       <= '0;
      pwm_q       <= '0;
      started_q   <= 1'b0;
      ldsel_q     <= '0;
      sseg_q      <= SEG_OFF;
      digit_idx_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pwm_q       <= pwm_d;
      started_q   <= started_d;
      ldsel_q     <= ldsel_d;
      sseg_q      <= sseg_d;
      digit_idx_q <= idx_q;
      tick_q      <= tick_d;
    end
  end

  assign o_ldsel     = ldsel_q;
  assign o_sseg_n    = sseg_q;
  assign o_digit_idx = digit_idx_q;
  assign o_scan_tick = tick_q;

endmodule

// File: tb/tb_led_n_mux.sv
// Directed bench for led_n_mux: three instances (4 digits/DIV 8, 4 digits/DIV 64,
// 6 digits/DIV 8) checked cycle by cycle against hand-derived expectations.
module tb_led_n_mux;

`ifdef LEDMUX_BLANK_EN
  localparam int TB_BLANK = 2;
`else
  localparam int TB_BLANK = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N_DIGITS=4, DIV=8
  logic            rst_a = 1'b1;
  logic [3:0][7:0] a_in_n = '1;
  logic [3:0]      a_en = 4'hF;
  logic [3:0]      a_bright = 4'd15;
  logic [3:0]      a_ldsel;
  logic [7:0]      a_sseg;
  logic [1:0]      a_idx;
  logic            a_tick;

  // Instance B: N_DIGITS=4, DIV=64
  logic            rst_b = 1'b1;
  logic [3:0]      b_bright = 4'd8;
  logic [3:0]      b_ldsel;
  logic [7:0]      b_sseg;
  logic [1:0]      b_idx;
  logic            b_tick;

  // Instance C: N_DIGITS=6, DIV=8
  logic            rst_c = 1'b1;
  logic [5:0][7:0] c_in_n = {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [5:0]      c_en = 6'h3F;
  logic [3:0]      c_bright = 4'd15;
  logic [5:0]      c_ldsel;
  logic [7:0]      c_sseg;
  logic [2:0]      c_idx;
  logic            c_tick;

  led_n_mux #(.N_DIGITS(4), .SEG_W(8), .DIV(8), .BLANK(2)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_in_n(a_in_n), .i_dig_en(a_en),
    .i_bright(a_bright), .o_ldsel(a_ldsel), .o_sseg_n(a_sseg),
    .o_digit_idx(a_idx), .o_scan_tick(a_tick)
  );

  led_n_mux #(.N_DIGITS(4), .SEG_W(8), .DIV(64), .BLANK(2)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_in_n(a_in_n), .i_dig_en(a_en),
    .i_bright(b_bright), .o_ldsel(b_ldsel), .o_sseg_n(b_sseg),
    .o_digit_idx(b_idx), .o_scan_tick(b_tick)
  );

  led_n_mux #(.N_DIGITS(6), .SEG_W(8), .DIV(8), .BLANK(2)) dut_c (
    .i_clk(clk), .i_reset(rst_c), .i_in_n(c_in_n), .i_dig_en(c_en),
    .i_bright(c_bright), .o_ldsel(c_ldsel), .o_sseg_n(c_sseg),
    .o_digit_idx(c_idx), .o_scan_tick(c_tick)
  );

  task automatic reset_a();
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a_ldsel !== 4'b0 || a_sseg !== 8'hFF || a_idx !== 2'd0 || a_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold ldsel=%b sseg=%h idx=%0d tick=%b want 0000/FF/0/0",
               a_ldsel, a_sseg, a_idx, a_tick);
    end
    reset_a();
    // Scan into slot 1, then hit reset between edges.
    for (int c = 0; c < 13; c++) @(negedge clk);
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    checks++;
    if (a_ldsel !== 4'b0 || a_sseg !== 8'hFF || a_idx !== 2'd0 || a_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ldsel=%b sseg=%h idx=%0d tick=%b want 0000/FF/0/0",
               a_ldsel, a_sseg, a_idx, a_tick);
    end
    @(negedge clk);
    rst_a = 1'b0;
    for (int c = 0; c < 9; c++) begin
      logic [3:0] exp_ldsel;
      int slot;
      @(negedge clk);
      slot = c / 8;
      exp_ldsel = ((c % 8) >= TB_BLANK) ? 4'(1 << slot) : 4'b0;
      checks++;
      if (a_ldsel !== exp_ldsel || a_idx !== 2'(slot) || a_tick !== (c == 8)) begin
        errors++;
        $display("FAIL reset_restart c=%0d ldsel=%b idx=%0d tick=%b want %b/%0d/%b",
                 c, a_ldsel, a_idx, a_tick, exp_ldsel, slot, (c == 8));
      end
    end
  endtask

  task automatic test_scan_order();
    a_in_n = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    a_en = 4'hF;
    a_bright = 4'd15;
    reset_a();
    for (int c = 0; c < 40; c++) begin
      int slot, k;
      logic [3:0] exp_ldsel;
      logic [7:0] exp_sseg;
      logic       exp_tick;
      @(negedge clk);
      slot = (c / 8) % 4;
      k = c % 8;
      exp_ldsel = (k >= TB_BLANK) ? 4'(1 << slot) : 4'b0;
      exp_sseg  = (k >= TB_BLANK) ? a_in_n[slot] : 8'hFF;
      exp_tick  = (k == 0) && (c >= 8);
      checks++;
      if (a_ldsel !== exp_ldsel || a_sseg !== exp_sseg) begin
        errors++;
        $display("FAIL scan_out c=%0d ldsel=%b sseg=%h want %b/%h", c, a_ldsel, a_sseg,
                 exp_ldsel, exp_sseg);
      end
      checks++;
      if (a_idx !== 2'(slot) || a_tick !== exp_tick) begin
        errors++;
        $display("FAIL scan_idx c=%0d idx=%0d tick=%b want %0d/%b", c, a_idx, a_tick,
                 slot, exp_tick);
      end
    end
  endtask

  task automatic test_enable();
    a_en = 4'b1011;
    reset_a();
    for (int c = 0; c < 32; c++) begin
      int slot, k;
      logic [3:0] exp_ldsel;
      logic [7:0] exp_sseg;
      @(negedge clk);
      slot = c / 8;
      k = c % 8;
      exp_ldsel = (k >= TB_BLANK && slot != 2) ? 4'(1 << slot) : 4'b0;
      exp_sseg  = (k >= TB_BLANK && slot != 2) ? a_in_n[slot] : 8'hFF;
      checks++;
      if (a_ldsel !== exp_ldsel || a_sseg !== exp_sseg || a_idx !== 2'(slot) ||
          a_tick !== (k == 0 && c >= 8)) begin
        errors++;
        $display("FAIL enable c=%0d ldsel=%b sseg=%h idx=%0d tick=%b want %b/%h/%0d/%b",
                 c, a_ldsel, a_sseg, a_idx, a_tick, exp_ldsel, exp_sseg, slot,
                 (k == 0 && c >= 8));
      end
    end
    a_en = 4'hF;
  endtask

  task automatic test_brightness();
    int lit_cnt;
    // Live changes: off, full on for slot 2, off again.
    a_bright = 4'd0;
    reset_a();
    for (int c = 0; c < 32; c++) begin
      int slot, k;
      logic [3:0] exp_ldsel;
      a_bright = (c >= 16 && c < 24) ? 4'd15 : 4'd0;
      @(negedge clk);
      slot = c / 8;
      k = c % 8;
      exp_ldsel = (a_bright == 4'd15 && k >= TB_BLANK) ? 4'(1 << slot) : 4'b0;
      checks++;
      if (a_ldsel !== exp_ldsel || (exp_ldsel == 4'b0 && a_sseg !== 8'hFF)) begin
        errors++;
        $display("FAIL bright_live c=%0d ldsel=%b sseg=%h want %b", c, a_ldsel, a_sseg,
                 exp_ldsel);
      end
    end
    a_bright = 4'd15;
    // Half brightness on the DIV=64 instance: pwm 0..7 lit.
    b_bright = 4'd8;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    lit_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      logic exp_lit;
      @(negedge clk);
      exp_lit = ((c % 16) < 8) && ((c % 64) >= TB_BLANK);
      if (b_ldsel != 4'b0) lit_cnt++;
      checks++;
      if (b_ldsel !== (exp_lit ? 4'b0001 : 4'b0000) ||
          b_sseg !== (exp_lit ? a_in_n[0] : 8'hFF)) begin
        errors++;
        $display("FAIL bright_half c=%0d ldsel=%b sseg=%h want lit=%b", c, b_ldsel, b_sseg,
                 exp_lit);
      end
    end
    checks++;
    if (lit_cnt != 32 - TB_BLANK) begin
      errors++;
      $display("FAIL bright_half_count lit=%0d want %0d", lit_cnt, 32 - TB_BLANK);
    end
  endtask

  task automatic test_blanking();
    int dark_cnt;
    reset_a();
    dark_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_ldsel == 4'b0) dark_cnt++;
    end
    checks++;
    if (dark_cnt != TB_BLANK) begin
      errors++;
      $display("FAIL blanking dark_cycles=%0d want %0d", dark_cnt, TB_BLANK);
    end
  endtask

  task automatic test_odd_count();
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    for (int c = 0; c < 56; c++) begin
      int slot, k;
      logic [5:0] exp_ldsel;
      @(negedge clk);
      slot = (c / 8) % 6;
      k = c % 8;
      exp_ldsel = (k >= TB_BLANK) ? 6'(1 << slot) : 6'b0;
      checks++;
      if (c_idx !== 3'(slot) || c_ldsel !== exp_ldsel ||
          c_sseg !== ((k >= TB_BLANK) ? c_in_n[slot] : 8'hFF)) begin
        errors++;
        $display("FAIL odd_scan c=%0d idx=%0d ldsel=%b sseg=%h want idx %0d ldsel %b",
                 c, c_idx, c_ldsel, c_sseg, slot, exp_ldsel);
      end
    end
    // Mid-slot reset while showing idx 3.
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    for (int c = 0; c < 28; c++) @(negedge clk);
    checks++;
    if (c_idx !== 3'd3) begin
      errors++;
      $display("FAIL odd_pre_reset idx=%0d want 3", c_idx);
    end
    @(posedge clk);
    #3 rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    for (int c = 0; c < 10; c++) begin
      int slot;
      @(negedge clk);
      slot = c / 8;
      checks++;
      if (c_idx !== 3'(slot) || c_tick !== (c == 8)) begin
        errors++;
        $display("FAIL odd_restart c=%0d idx=%0d tick=%b want %0d/%b", c, c_idx, c_tick,
                 slot, (c == 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_enable();
    test_brightness();
    test_blanking();
    test_odd_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_n_mux.md
LED_N_MUX -- requirements
Module: led_n_mux

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SEG_W, default 8, segment lines per digit (7 segments + DP).
REQ-003 Parameter DIV, default 50000, clock cycles per digit slot, legal range DIV >= 4.
REQ-004 Parameter BLANK, default 16, dark cycles at the start of each slot; legal range 1..DIV-1; used only when LEDMUX_BLANK_EN is defined.
REQ-005 i_clk  input  1  system clock, rising edge.
REQ-006 i_reset  input  1  reset, asynchronous, active-high.
REQ-007 i_in_n  input  N_DIGITS x SEG_W  per-digit segment pattern, active-low; index 0 = rightmost digit.
REQ-008 i_dig_en  input  N_DIGITS  per-digit enable, active-high.
REQ-009 i_bright  input  4  brightness: 0 = off, 15 = full on.
REQ-010 o_ldsel  output  N_DIGITS  digit select, active-high, one-hot or all-zero.
REQ-011 o_sseg_n  output  SEG_W  segment drive, active-low.
REQ-012 o_digit_idx  output  clog2(N_DIGITS)  index of the current slot.
REQ-013 o_scan_tick  output  1  one-cycle pulse when a new slot begins.

Function
REQ-014 Slot counter cnt SHALL count 0..DIV-1; at DIV-1 it SHALL wrap to 0 and advance idx.
REQ-015 idx SHALL advance 0,1,..,N_DIGITS-1,0; wrap SHALL be explicit, so non-power-of-2 N_DIGITS never visits an illegal index.
REQ-016 Disabled digits SHALL still consume their full slot (constant refresh rate); only their drive is suppressed.
REQ-017 PWM counter pwm SHALL be 4 bits, free-running, +1 every cycle, wrapping 15->0.
REQ-018 lit SHALL be true when i_dig_en[idx] is 1 AND (pwm < i_bright OR i_bright == 15) AND blanking is inactive.
REQ-019 When lit: o_ldsel SHALL be one-hot at bit idx, and o_sseg_n SHALL equal i_in_n[idx].
REQ-020 When not lit: o_ldsel SHALL be 0 and o_sseg_n SHALL be all ones.
REQ-021 All outputs SHALL be registered, with latency 1 cycle from the internal cnt/idx/pwm state; outputs SHALL be glitch-free.
REQ-022 o_scan_tick SHALL assert in the same output cycle in which o_digit_idx first shows the new index.
REQ-023 i_in_n, i_dig_en and i_bright SHALL be sampled live every cycle; a change SHALL appear on the outputs 1 cycle later.

Reset
REQ-024 While i_reset is high, outputs SHALL immediately be: o_ldsel=0, o_sseg_n=all ones, o_digit_idx=0, o_scan_tick=0.
REQ-025 While i_reset is high, internal state SHALL be: cnt=0, idx=0, pwm=0.
REQ-026 Reset asserted mid-scan SHALL abort the current slot; after release, scanning SHALL restart at digit 0 with a full slot.
REQ-027 o_scan_tick SHALL NOT pulse on the first slot after reset.

Configuration
REQ-028 With LEDMUX_BLANK_EN defined: for cnt < BLANK, the block SHALL force not-lit (anti-ghosting dead time).
REQ-029 Without LEDMUX_BLANK_EN: there SHALL be no blanking logic, and BLANK SHALL be ignored.

Structure
REQ-030 Package led_mux_pkg SHALL hold: seg_t typedef, SEG_BLANK constant (all ones), and brightness constants BRIGHT_OFF=0 and BRIGHT_FULL=15.
REQ-031 The slot prescaler SHALL be sub-module led_slot_cnt (mod-DIV counter with a tick output); all other logic stays in led_n_mux.

Verification (N_DIGITS=4, DIV=8, BLANK=2, i_bright=15, i_dig_en=4'hF unless stated)
REQ-032 Reset: assert i_reset asynchronously between clock edges while scanning -> o_ldsel=0 and o_sseg_n=8'hFF before the next edge; after release, digit 0 is shown for 8 cycles.
REQ-033 Scan order: i_in_n = {B0,A4,F9,C0} -> o_ldsel/o_sseg_n = 0001/C0, 0010/F9, 0100/A4, 1000/B0, each 8 cycles, then wraps to 0001; o_scan_tick pulses every 8 cycles.
REQ-034 Enable: i_dig_en=4'b1011 -> slot 2 shows o_ldsel=0 and o_sseg_n=FF for 8 cycles, and slot timing is unchanged.
REQ-035 Brightness: i_bright=0 -> o_ldsel always 0; i_bright=8 with DIV=64 -> lit exactly 8 of every 16 cycles; i_bright=15 -> continuously lit.
REQ-036 Blanking: with LEDMUX_BLANK_EN defined -> cycles 0-1 of each slot are dark and cycles 2-7 are lit; without the macro -> all 8 cycles are lit.
REQ-037 Odd count: N_DIGITS=6 -> idx sequence 0..5,0 with no idx 6 or 7; mid-slot reset at idx 3 -> restart at idx 0.
